// File: rtl/wb_uart_host_pkg.sv
// Shared definitions for the UART-to-Wishbone host bridge.
// Holds the command/reply byte codes, the command FSM and UART receiver
// state encodings, and the clocks-per-bit helper.
package wb_uart_host_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
   localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
   localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
   localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_ADR,
      ST_GET_DAT,
      ST_BUS,
      ST_REPLY
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Clocks per bit; integer division, caller must keep the result >= 16.
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_8n1_phy.sv
// Bit-level 8N1 UART receiver and transmitter.
//   clk, rst_n        : clock, asynchronous active-low reset
//   rx                : serial input (asynchronous, idle high)
//   tx                : serial output (idle high)
//   rx_data/rx_valid  : received byte, one-clock valid pulse at stop sample
//   rx_ferr           : one-clock pulse when the stop bit sampled low
//   tx_data/tx_valid/tx_ready : byte handshake; ready rises in the last
//                       clock of a stop bit so frames can run back-to-back
module uart_8n1_phy
   import wb_uart_host_pkg::*;
#(
   parameter int unsigned DIV = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_ferr,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready
);

   localparam int unsigned     CW        = $clog2(DIV);
   localparam logic [CW-1:0]   LAST      = CW'(DIV - 1);
   localparam logic [CW-1:0]   HALF_LAST = CW'(DIV / 2 - 1);

   // ---------------- receiver ----------------
   logic [2:0]    rx_sync;  // [1] synchronized sample, [2] previous sample
   rx_state_t     rx_st, rx_nxt;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_sh;
   logic          rx_tick;

   assign rx_tick = (rx_st == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == LAST);
   assign rx_data = rx_sh;

   always_comb begin
      rx_nxt = rx_st;
      case (rx_st)
         RX_IDLE:  if (rx_sync[2] && !rx_sync[1]) rx_nxt = RX_START;
         RX_START: if (rx_tick) rx_nxt = rx_sync[1] ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_nxt = RX_STOP;
         RX_STOP:  if (rx_tick) rx_nxt = RX_IDLE;
         default:  rx_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync  <= '1;
         rx_st    <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_sync  <= {rx_sync[1:0], rx};
         rx_st    <= rx_nxt;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         if (rx_st == RX_IDLE || rx_tick) rx_cnt <= '0;
         else                             rx_cnt <= rx_cnt + 1'b1;
         if (rx_st == RX_START) rx_bit <= '0;
         if (rx_st == RX_DATA && rx_tick) begin
            rx_sh  <= {rx_sync[1], rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
         end
         if (rx_st == RX_STOP && rx_tick) begin
            rx_valid <= rx_sync[1];
            rx_ferr  <= !rx_sync[1];
         end
      end
   end

   // ---------------- transmitter ----------------
   // The shift register fills with ones, so after the stop bit the line
   // rests high straight from the register with no output mux.
   logic [9:0]    tx_sh;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic          tx_busy;

   assign tx       = tx_sh[0];
   assign tx_ready = !tx_busy || (tx_bit == 4'd9 && tx_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sh   <= '1;
         tx_cnt  <= '0;
         tx_bit  <= '0;
         tx_busy <= 1'b0;
      end else if (tx_valid && tx_ready) begin
         tx_sh   <= {1'b1, tx_data, 1'b0};
         tx_cnt  <= '0;
         tx_bit  <= '0;
         tx_busy <= 1'b1;
      end else if (tx_busy) begin
         if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 4'd1;
            tx_sh  <= {1'b1, tx_sh[9:1]};
            if (tx_bit == 4'd9) tx_busy <= 1'b0;
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_uart_host_bridge.sv
// UART-to-Wishbone host bridge: decodes 'W'/'R' command frames from the
// UART, runs one 32-bit Wishbone classic cycle, and replies on the UART.
//   wb_clk_i, wb_rst_n_i : clock, asynchronous active-low reset
//   uart_rx_i, uart_tx_o : 8N1 serial lines
//   wb_*_o / wb_*_i      : Wishbone B3 classic initiator port
//   busy_o               : high whenever the command FSM is not idle
module wb_uart_host_bridge
   import wb_uart_host_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 24000000,
   parameter int unsigned BAUD         = 115200,
   parameter int unsigned BYTE_TIMEOUT = 20,
   parameter int unsigned WB_TIMEOUT   = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic        uart_rx_i,
   output logic        uart_tx_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   output logic        busy_o
);

   localparam int unsigned   DIV      = calc_div(CLK_FREQ_HZ, BAUD);
   localparam int unsigned   GAP      = BYTE_TIMEOUT * DIV;
   localparam int unsigned   GW       = $clog2(GAP);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
   localparam logic [7:0]    TMO_LAST = 8'(WB_TIMEOUT - 1);

   state_t        state, nxt;
   logic [7:0]    rx_data;
   logic          rx_valid, rx_ferr, tx_ready, tx_valid;
   logic [1:0]    byte_cnt;
   logic          is_wr;
   logic [31:0]   adr_buf, dat_buf, rsp_buf;
   logic [2:0]    rsp_cnt;
   logic [7:0]    tmo_cnt;
   logic [GW-1:0] gap_cnt;
   logic          collecting, gap_to, term;

   uart_8n1_phy #(.DIV(DIV)) u_phy (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_n_i),
      .rx       (uart_rx_i),
      .tx       (uart_tx_o),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr),
      .tx_data  (rsp_buf[31:24]),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   assign collecting = (state == ST_GET_ADR) || (state == ST_GET_DAT);
   assign gap_to     = collecting && (gap_cnt == GAP_LAST);
   assign term       = (state == ST_BUS) && wb_cyc_o &&
                       (wb_ack_i || wb_err_i || tmo_cnt == TMO_LAST);
   assign tx_valid   = (state == ST_REPLY);
   assign busy_o     = (state != ST_IDLE);

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:
            if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) nxt = ST_GET_ADR;
         ST_GET_ADR:
            if (rx_ferr || gap_to)                 nxt = ST_IDLE;
            else if (rx_valid && byte_cnt == 2'd3) nxt = is_wr ? ST_GET_DAT : ST_BUS;
         ST_GET_DAT:
            if (rx_ferr || gap_to)                 nxt = ST_IDLE;
            else if (rx_valid && byte_cnt == 2'd3) nxt = ST_BUS;
         ST_BUS:
            if (term) nxt = ST_REPLY;
         ST_REPLY:
            if (tx_ready && rsp_cnt == 3'd1) nxt = ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state    <= ST_IDLE;
         byte_cnt <= '0;
         is_wr    <= 1'b0;
         adr_buf  <= '0;
         dat_buf  <= '0;
         rsp_buf  <= '0;
         rsp_cnt  <= '0;
         tmo_cnt  <= '0;
         gap_cnt  <= '0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_sel_o <= '0;
         wb_we_o  <= 1'b0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
      end else begin
         state <= nxt;

         if (!collecting)   byte_cnt <= '0;
         else if (rx_valid) byte_cnt <= byte_cnt + 2'd1;

         if (!collecting || rx_valid) gap_cnt <= '0;
         else                         gap_cnt <= gap_cnt + 1'b1;

         if (state == ST_IDLE && rx_valid)    is_wr   <= (rx_data == CMD_WR);
         if (state == ST_GET_ADR && rx_valid) adr_buf <= {adr_buf[23:0], rx_data};
         if (state == ST_GET_DAT && rx_valid) dat_buf <= {dat_buf[23:0], rx_data};

         // First BUS clock loads the buffers onto the bus (cyc still low),
         // so the last field byte has landed and cyc rises one clock later.
         if (state == ST_BUS) begin
            if (!wb_cyc_o) begin
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               wb_adr_o <= adr_buf;
               wb_dat_o <= dat_buf;
               wb_we_o  <= is_wr;
               wb_sel_o <= 4'hf;
               tmo_cnt  <= '0;
            end else if (term) begin
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               // err beats ack; ack beats the timeout.
               if (wb_err_i || !wb_ack_i) begin
                  rsp_buf <= {RSP_ERR, 24'h0};
                  rsp_cnt <= 3'd1;
               end else if (wb_we_o) begin
                  rsp_buf <= {RSP_OK, 24'h0};
                  rsp_cnt <= 3'd1;
               end else begin
                  rsp_buf <= wb_dat_i;
                  rsp_cnt <= 3'd4;
               end
            end else begin
               tmo_cnt <= tmo_cnt + 8'd1;
            end
         end

         if (state == ST_REPLY && tx_ready) begin
            rsp_buf <= {rsp_buf[23:0], 8'h00};
            rsp_cnt <= rsp_cnt - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_wb_uart_host_bridge.sv
`timescale 1ns/1ps
module tb_wb_uart_host_bridge;

   localparam int unsigned CLK_HZ = 24000000;
   localparam int unsigned BAUD_R = 1500000;
   localparam int unsigned DIV    = CLK_HZ / BAUD_R;
   localparam int unsigned BT     = 20;
   localparam int unsigned WBT    = 255;

   logic        clk = 1'b0;
   logic        wb_rst_n_i = 1'b0;
   logic        uart_rx_i = 1'b1;
   logic        uart_tx_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o, busy_o;
   logic        wb_ack_i = 1'b0;
   logic        wb_err_i = 1'b0;

   always #5 clk = ~clk;

   wb_uart_host_bridge #(
      .CLK_FREQ_HZ  (CLK_HZ),
      .BAUD         (BAUD_R),
      .BYTE_TIMEOUT (BT),
      .WB_TIMEOUT   (WBT)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (wb_rst_n_i),
      .uart_rx_i  (uart_rx_i),
      .uart_tx_o  (uart_tx_o),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_sel_o   (wb_sel_o),
      .wb_we_o    (wb_we_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i),
      .busy_o     (busy_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   int ncyc = 0;
   always @(posedge clk) ncyc <= ncyc + 1;

   // Slave behaviour: 0 ack, 1 err, 2 ack+err together, 3 silent.
   int          slv_mode = 0;
   int          slv_dly  = 0;
   logic [31:0] slv_rdata = '0;
   assign wb_dat_i = slv_rdata;

   int          ntxn = 0, stab_bad = 0, wcnt = 0, cyc_len = 0, term_t = 0;
   logic [31:0] t_adr = '0, t_dat = '0;
   logic        t_we = 1'b0;
   logic [3:0]  t_sel = '0;
   logic        cyc_p = 1'b0;

   always @(negedge clk) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o === 1'b1) begin
         if (!cyc_p) begin
            ntxn++;
            t_adr = wb_adr_o; t_dat = wb_dat_o; t_we = wb_we_o; t_sel = wb_sel_o;
            wcnt = 0; cyc_len = 0;
         end else if (wb_adr_o !== t_adr || wb_dat_o !== t_dat ||
                      wb_we_o !== t_we || wb_sel_o !== t_sel) begin
            stab_bad++;
         end
         if (wb_stb_o !== 1'b1) stab_bad++;
         cyc_len++;
         if (wcnt == slv_dly) begin
            case (slv_mode)
               0: wb_ack_i = 1'b1;
               1: wb_err_i = 1'b1;
               2: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
               default: ;
            endcase
         end
         wcnt++;
      end else if (cyc_p) begin
         term_t = ncyc;
      end
      cyc_p = (wb_cyc_o === 1'b1);
   end

   // UART line monitor: decodes every frame on uart_tx_o.
   logic [7:0] rxq[$];
   int         stq[$];
   int         mon_ferr = 0;

   initial begin : monitor
      logic [7:0] b;
      int         st;
      forever begin
         @(negedge clk);
         if (wb_rst_n_i && uart_tx_o === 1'b0) begin
            st = ncyc;
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = uart_tx_o;
            end
            repeat (DIV) @(negedge clk);
            if (uart_tx_o !== 1'b1) mon_ferr++;
            rxq.push_back(b);
            stq.push_back(st);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_v);
      uart_rx_i = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx_i = b[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rx_i = stop_v;
      repeat (DIV) @(negedge clk);
      uart_rx_i = 1'b1;
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
      send_byte(wr ? 8'h57 : 8'h52, 1'b1);
      for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
      if (wr) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1);
   endtask

   // Reference: what the bridge must answer for a given slave behaviour.
   function automatic void model(input logic wr, input logic [31:0] rdat, input int mode,
                                 output int nrep, output logic [31:0] rep);
      if (mode != 0)  begin nrep = 1; rep = 32'h4500_0000; end
      else if (wr)    begin nrep = 1; rep = 32'h4B00_0000; end
      else            begin nrep = 4; rep = rdat;          end
   endfunction

   int txn_base = 0, rq_base = 0, stab_base = 0;

   task automatic prep(input int mode, input int dly, input logic [31:0] rdat);
      slv_mode  = mode;
      slv_dly   = dly;
      slv_rdata = rdat;
      txn_base  = ntxn;
      rq_base   = rxq.size();
      stab_base = stab_bad;
   endtask

   task automatic check_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input int mode, input int dly, input logic [31:0] rdat);
      int          nrep, exp_len;
      logic [31:0] rep;
      logic [7:0]  eb;
      model(wr, rdat, mode, nrep, rep);
      exp_len = (mode == 3) ? int'(WBT) : dly + 1;
      for (int i = 0; i < nrep * 10 * int'(DIV) + int'(WBT) + 200 &&
                      rxq.size() < rq_base + nrep; i++)
         @(negedge clk);
      repeat (12 * DIV) @(negedge clk);
      chk("txn_count", ntxn - txn_base, 1);
      chk("adr", t_adr, a);
      chk("we", {31'b0, t_we}, {31'b0, wr});
      chk("sel", {28'b0, t_sel}, 32'hf);
      if (wr) chk("wdat", t_dat, d);
      chk("cyc_len", cyc_len, exp_len);
      chk("bus_stable", stab_bad - stab_base, 0);
      chk("reply_count", rxq.size() - rq_base, nrep);
      for (int k = 0; k < nrep && rq_base + k < rxq.size(); k++) begin
         eb = rep[31 - 8*k -: 8];
         chk("reply_byte", {24'b0, rxq[rq_base + k]}, {24'b0, eb});
      end
      if (stq.size() > rq_base) chk("reply_latency", {31'b0, (stq[rq_base] - term_t) <= 2}, 1);
      for (int k = 1; k < nrep && rq_base + k < stq.size(); k++)
         chk("back_to_back", stq[rq_base + k] - stq[rq_base + k - 1], 10 * DIV);
      chk("busy_idle", {31'b0, busy_o}, 0);
   endtask

   task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input int mode, input int dly, input logic [31:0] rdat);
      prep(mode, dly, rdat);
      send_cmd(wr, a, d);
      check_txn(wr, a, d, mode, dly, rdat);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete, total=%0d", total);
      $fatal(1);
   end

   initial begin
      logic        wr;
      logic [31:0] a, d, r;
      int          mode, dly;

      repeat (5) @(negedge clk);
      chk("rst_tx", {31'b0, uart_tx_o}, 1);
      chk("rst_cyc", {31'b0, wb_cyc_o}, 0);
      chk("rst_stb", {31'b0, wb_stb_o}, 0);
      chk("rst_we", {31'b0, wb_we_o}, 0);
      chk("rst_sel", {28'b0, wb_sel_o}, 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_dat", wb_dat_o, 0);
      chk("rst_busy", {31'b0, busy_o}, 0);
      wb_rst_n_i = 1'b1;
      repeat (4 * DIV) @(negedge clk);

      run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 3, 32'h0);
      run_txn(1'b0, 32'h0000_0020, 32'h0, 0, 1, 32'h1234_5678);
      run_txn(1'b0, 32'h0000_0040, 32'h0, 1, 2, 32'h5555_AAAA);
      run_txn(1'b1, 32'h0000_0044, 32'h0000_0005, 3, 0, 32'h0);
      run_txn(1'b0, 32'h0000_0048, 32'h0, 2, 0, 32'h0000_A5A5);
      run_txn(1'b0, 32'h0000_004C, 32'h0, 0, int'(WBT) - 1, 32'hCAFE_F00D);

      for (int n = 0; n < 5; n++) begin
         wr   = 1'($urandom_range(0, 1));
         a    = $urandom;
         d    = $urandom;
         r    = $urandom;
         mode = $urandom_range(0, 2);
         dly  = $urandom_range(0, 6);
         run_txn(wr, a, d, mode, dly, r);
      end

      // Framing error on the third byte: command abandoned.
      prep(0, 0, 32'h0);
      send_byte(8'h52, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b0);
      repeat (2 * DIV) @(negedge clk);
      send_byte(8'h00, 1'b1);
      send_byte(8'h20, 1'b1);
      repeat (2 * DIV) @(negedge clk);
      chk("ferr_busy", {31'b0, busy_o}, 0);
      repeat (12 * DIV) @(negedge clk);
      chk("ferr_no_txn", ntxn - txn_base, 0);
      chk("ferr_no_reply", rxq.size() - rq_base, 0);

      // Unknown first byte is ignored, the following read is served.
      prep(0, 0, 32'h0);
      send_byte(8'h00, 1'b1);
      repeat (2 * DIV) @(negedge clk);
      chk("unknown_busy", {31'b0, busy_o}, 0);
      run_txn(1'b0, 32'h0000_0024, 32'h0, 0, 2, 32'h0BAD_CAFE);

      // Short low glitch inside an address field decodes nothing.
      prep(0, 1, 32'h7654_3210);
      send_byte(8'h52, 1'b1);
      send_byte(8'h00, 1'b1);
      uart_rx_i = 1'b0;
      repeat (DIV / 2 - 2) @(negedge clk);
      uart_rx_i = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h30, 1'b1);
      check_txn(1'b0, 32'h0000_0030, 32'h0, 0, 1, 32'h7654_3210);

      // Inter-byte timeout returns to idle; next command works.
      prep(0, 0, 32'h0);
      send_byte(8'h52, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      repeat (25 * DIV) @(negedge clk);
      chk("gap_busy", {31'b0, busy_o}, 0);
      chk("gap_no_txn", ntxn - txn_base, 0);
      run_txn(1'b0, 32'h0000_0034, 32'h0, 0, 0, 32'h89AB_CDEF);

      // Reset while cyc is high.
      prep(3, 0, 32'h0);
      send_cmd(1'b0, 32'h0000_0060, 32'h0);
      for (int i = 0; i < 40 * int'(DIV) && wb_cyc_o !== 1'b1; i++) @(negedge clk);
      chk("rst_cyc_pre", {31'b0, wb_cyc_o}, 1);
      repeat (5) @(negedge clk);
      #2 wb_rst_n_i = 1'b0;
      #1;
      chk("rst_cyc_drop", {31'b0, wb_cyc_o}, 0);
      chk("rst_stb_drop", {31'b0, wb_stb_o}, 0);
      chk("rst_busy_drop", {31'b0, busy_o}, 0);
      @(negedge clk);
      wb_rst_n_i = 1'b1;
      repeat (2 * DIV) @(negedge clk);

      // Reset during a reply start bit.
      prep(0, 0, 32'h0F0F_0F0F);
      send_cmd(1'b0, 32'h0000_0064, 32'h0);
      for (int i = 0; i < 40 * int'(DIV) && uart_tx_o !== 1'b0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("rst_tx_pre", {31'b0, uart_tx_o}, 0);
      #2 wb_rst_n_i = 1'b0;
      #1;
      chk("rst_tx_high", {31'b0, uart_tx_o}, 1);
      @(negedge clk);
      wb_rst_n_i = 1'b1;
      repeat (12 * DIV) @(negedge clk);

      run_txn(1'b1, 32'h0000_0050, 32'h0BAD_F00D, 0, 2, 32'h0);
      chk("reply_stop_bits", mon_ferr, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
